cim_bank_wr_ctrl: RTL and testbench
===================================

Name: cim_bank_wr_ctrl

Overview:
Parametrised write controller for the CIM macro's weight-storage banks. It generalises the 2-bank, purely combinational address router into an N-bank, clocked write sequencer. Incoming write requests (data, row address, bank select) arrive over a valid/ready handshake and are buffered in a small FIFO. Each request is then sequenced into a timed SETUP/WRITE/RECOVER pulse on the selected bank. It sits between the host weight-load interface and the bank array.

Parameters:
DATA_W, 24, width of one row write word
ADDR_W, 8, row address width per bank
NUM_BANKS, 2, number of banks (>=2, need not be a power of two)
SEL_W, $clog2(NUM_BANKS), bank select width (derived, localparam)
FIFO_DEPTH, 4, request buffer depth (power of two, >=2)
WR_CYCLES, 2, cycles bank_we is held high per write (>=1)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  write request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_data  in  DATA_W  row data
in_addr  in  ADDR_W  row address
in_bank  in  SEL_W  target bank index
bank_data  out  DATA_W  shared data bus to all banks
bank_addr  out  NUM_BANKS*ADDR_W  per-bank address; slice k = bank k
bank_we  out  NUM_BANKS  one-hot write enable
busy  out  1  FIFO non-empty or FSM not IDLE
wr_done  out  1  one-cycle pulse per completed write
err  out  1  sticky flag, set when a request targets in_bank >= NUM_BANKS
err_clr  in  1  clears err

Behaviour:
- Reset (async assert, sync release): FIFO empty; FSM in IDLE. bank_data, bank_addr, bank_we, wr_done and err are all 0. busy=0, in_ready=1. Reset mid-write aborts immediately; the FIFO is discarded.
- in_ready = !fifo_full. A push is blocked when full, even if a pop occurs in the same cycle. Push and pop in the same cycle are legal when the FIFO is not full.
- FSM states: IDLE, SETUP, WRITE, RECOVER.
  - IDLE: if the FIFO is non-empty, pop the head. If bank is in range, latch it and go to SETUP. If out of range, set err, drop the entry, and stay in IDLE (one cycle consumed, no bank activity).
  - SETUP (1 cycle): drive bank_data and the selected bank_addr slice; we=0.
  - WRITE (WR_CYCLES cycles, down-counter): bank_we[sel]=1; data and address held.
  - RECOVER (1 cycle): we=0; address and data held; wr_done=1. Then go to IDLE.
- All bank outputs are registered. Non-selected bank_addr slices are always 0. bank_data returns to 0 in IDLE.
- Latency: request accepted at cycle T into an empty FIFO in IDLE → pop at T+1 (IDLE) → SETUP at T+2 → we high for T+3..T+2+WR_CYCLES → wr_done at T+3+WR_CYCLES.
- Throughput: one write per WR_CYCLES+3 cycles. Back-to-back requests are never merged.
- err: set on an out-of-range pop. err_clr clears it; set wins over a simultaneous clear.
- FIFO pointers are ADDR-width $clog2(FIFO_DEPTH)+1 and wrap naturally. Full/empty are decided by the MSB compare.
- Inputs are sampled only on handshake. Input changes while in_valid=0 have no effect.

Decomposition:
- Package cim_pkg holds:
  - FSM state typedef (IDLE/SETUP/WRITE/RECOVER)
  - default DATA_W/ADDR_W constants, shared with the other macro blocks
- One sub-module, cim_req_fifo, parametrised by width (DATA_W+ADDR_W+SEL_W) and depth. It exposes push/pop/full/empty.
- The FSM and output registers live in the top level.

Test Plan:
1. Reset, then a single request (data 24'hA5A5A5, addr 8'h3C, bank 1), NUM_BANKS=2, WR_CYCLES=2 → SETUP at T+2; bank_we=2'b10 at T+3..T+4; bank_addr[15:8]=8'h3C; bank_addr[7:0]=0; wr_done at T+5; busy low at T+6.
2. NUM_BANKS=4, push 6 requests continuously (banks 0,1,2,3,0,1) → in_ready drops after 4 entries plus those already popped. Writes complete in order, one every 5 cycles. bank_we takes 0001, 0010, 0100, 1000, 0001, 0010.
3. NUM_BANKS=3, request to bank 3, then a valid request to bank 2 → err=1 with no we pulse for the first; the second writes normally. err_clr pulse → err=0.
4. err_clr asserted on the same cycle as a new out-of-range pop → err stays 1.
5. Assert rst_n=0 during WRITE → bank_we, bank_addr, bank_data go 0 without waiting for a clock edge. After release: FIFO empty, in_ready=1, no wr_done.
6. Fill the FIFO to full while popping → a push in the full cycle is refused (in_ready=0). The entry is accepted the next cycle, with no loss or duplication across pointer wrap (≥10 requests, data checked by scoreboard).

Source files
------------

// File: rtl/cim_pkg.sv
// Shared definitions for the CIM macro blocks.
//   CIM_DATA_W / CIM_ADDR_W : default row word and row address widths
//   wr_state_e              : bank write sequencer states
package cim_pkg;

  localparam int CIM_DATA_W = 24;
  localparam int CIM_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RECOVER = 2'd3
  } wr_state_e;

endpackage

// File: rtl/cim_req_fifo.sv
// Request buffer for the bank write controller.
// Show-ahead FIFO: pop_data always presents the head entry while !empty.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, push_data : write an entry (ignored when full)
//   pop             : discard the head entry (ignored when empty)
//   pop_data        : head entry
//   full, empty     : occupancy flags
module cim_req_fifo
  import cim_pkg::*;
#(
  parameter int WIDTH = CIM_DATA_W + CIM_ADDR_W + 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // Pointers carry one extra wrap bit: equal index with differing MSB
  // means the buffer is full, fully equal pointers mean empty.
  assign full     = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                    (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop_data = mem_q[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/cim_bank_wr_ctrl.sv
// N-bank write sequencer for the CIM weight-storage banks.
// Requests are buffered, then each one is played out on its bank as a
// SETUP / WRITE (WR_CYCLES) / RECOVER sequence.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid/in_ready           : request handshake
//   in_data, in_addr, in_bank   : row word, row address, target bank
//   bank_data                   : shared data bus to all banks
//   bank_addr                   : per-bank address, slice k belongs to bank k
//   bank_we                     : one-hot write enable
//   busy                        : work pending or in progress
//   wr_done                     : one pulse per completed write
//   err, err_clr                : sticky out-of-range bank flag and its clear
module cim_bank_wr_ctrl
  import cim_pkg::*;
#(
  parameter int DATA_W     = CIM_DATA_W,
  parameter int ADDR_W     = CIM_ADDR_W,
  parameter int NUM_BANKS  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int WR_CYCLES  = 2,
  localparam int SEL_W     = $clog2(NUM_BANKS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [ADDR_W-1:0]           in_addr,
  input  logic [SEL_W-1:0]            in_bank,
  output logic [DATA_W-1:0]           bank_data,
  output logic [NUM_BANKS*ADDR_W-1:0] bank_addr,
  output logic [NUM_BANKS-1:0]        bank_we,
  output logic                        busy,
  output logic                        wr_done,
  output logic                        err,
  input  logic                        err_clr
);

  localparam int FIFO_W = DATA_W + ADDR_W + SEL_W;
  localparam int CNT_W  = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [FIFO_W-1:0] fifo_head;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_addr;
  logic [SEL_W-1:0]  head_bank;
  logic              head_in_range;

  wr_state_e                   state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [DATA_W-1:0]           req_data_q, req_data_d;
  logic [ADDR_W-1:0]           req_addr_q, req_addr_d;
  logic [SEL_W-1:0]            req_sel_q, req_sel_d;
  logic                        err_q, err_d;
  logic [DATA_W-1:0]           bank_data_q, bank_data_d;
  logic [NUM_BANKS*ADDR_W-1:0] bank_addr_q, bank_addr_d;
  logic [NUM_BANKS-1:0]        bank_we_q, bank_we_d;
  logic                        wr_done_q, wr_done_d;

  assign in_ready = !fifo_full;

  cim_req_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid && in_ready),
    .push_data ({in_data, in_addr, in_bank}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_data, head_addr, head_bank} = fifo_head;
  // Widen by one bit so NUM_BANKS itself is representable in the compare.
  assign head_in_range = ({1'b0, head_bank} < (SEL_W + 1)'(NUM_BANKS));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_data_d = req_data_q;
    req_addr_d = req_addr_q;
    req_sel_d  = req_sel_q;
    err_d      = err_q;
    fifo_pop   = 1'b0;

    // A set later in this block overrides the clear.
    if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_in_range) begin
            req_data_d = head_data;
            req_addr_d = head_addr;
            req_sel_d  = head_bank;
            state_d    = ST_SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        cnt_d   = CNT_W'(WR_CYCLES - 1);
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (cnt_q == '0) begin
          state_d = ST_RECOVER;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bank outputs are registered from the next state so they line up with
  // the state they belong to rather than lagging it by a cycle.
  always_comb begin
    bank_data_d = '0;
    bank_addr_d = '0;
    bank_we_d   = '0;
    wr_done_d   = (state_d == ST_RECOVER);
    if (state_d != ST_IDLE) begin
      bank_data_d = req_data_d;
      for (int k = 0; k < NUM_BANKS; k++) begin
        if (req_sel_d == SEL_W'(k)) begin
          bank_addr_d[k*ADDR_W +: ADDR_W] = req_addr_d;
          bank_we_d[k]                    = (state_d == ST_WRITE);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_data_q  <= '0;
      req_addr_q  <= '0;
      req_sel_q   <= '0;
      err_q       <= 1'b0;
      bank_data_q <= '0;
      bank_addr_q <= '0;
      bank_we_q   <= '0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_data_q  <= req_data_d;
      req_addr_q  <= req_addr_d;
      req_sel_q   <= req_sel_d;
      err_q       <= err_d;
      bank_data_q <= bank_data_d;
      bank_addr_q <= bank_addr_d;
      bank_we_q   <= bank_we_d;
      wr_done_q   <= wr_done_d;
    end
  end

  assign bank_data = bank_data_q;
  assign bank_addr = bank_addr_q;
  assign bank_we   = bank_we_q;
  assign wr_done   = wr_done_q;
  assign err       = err_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_cim_bank_wr_ctrl.sv
// Self-checking bench for cim_bank_wr_ctrl (3 banks, WR_CYCLES=2, depth 4).
// Per-cycle directed vectors cover single writes, error handling and
// err_clr priority; hand-written sequences cover a saturated request
// stream with back-pressure and reset in the middle of a write.
module tb_cim_bank_wr_ctrl;

  localparam int DATA_W    = 24;
  localparam int ADDR_W    = 8;
  localparam int NUM_BANKS = 3;
  localparam int SEL_W     = 2;
  localparam int N_VEC     = 21;
  localparam int N_STREAM  = 12;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_W-1:0]           in_data;
  logic [ADDR_W-1:0]           in_addr;
  logic [SEL_W-1:0]            in_bank;
  logic [DATA_W-1:0]           bank_data;
  logic [NUM_BANKS*ADDR_W-1:0] bank_addr;
  logic [NUM_BANKS-1:0]        bank_we;
  logic                        busy;
  logic                        wr_done;
  logic                        err;
  logic                        err_clr;

  always #5 clk = ~clk;

  cim_bank_wr_ctrl #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .NUM_BANKS  (NUM_BANKS),
    .FIFO_DEPTH (4),
    .WR_CYCLES  (2)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .in_bank   (in_bank),
    .bank_data (bank_data),
    .bank_addr (bank_addr),
    .bank_we   (bank_we),
    .busy      (busy),
    .wr_done   (wr_done),
    .err       (err),
    .err_clr   (err_clr)
  );

  typedef struct {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic [SEL_W-1:0]  bank;
    logic              clr;
    logic              e_ready;
    logic [23:0]       e_data;
    logic [23:0]       e_addr;
    logic [2:0]        e_we;
    logic              e_busy;
    logic              e_done;
    logic              e_err;
  } vec_t;

  vec_t vecs [N_VEC];

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard for the streaming sequence.
  logic              mon_en = 1'b0;
  int                cyc = 0;
  int                n_done = 0;
  int                last_done_cyc = 0;
  logic [SEL_W-1:0]  exp_bank_q [$];
  logic [DATA_W-1:0] exp_data_q [$];
  logic [ADDR_W-1:0] exp_addr_q [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid = v.valid;
    in_data  = v.data;
    in_addr  = v.addr;
    in_bank  = v.bank;
    err_clr  = v.clr;
  endtask

  // Outputs change only on clock edges, so the falling edge is a safe
  // place to compare them and to record write completions.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (bank_we != '0) begin
        checkOutput("stream.we_pending", 32'(exp_bank_q.size() != 0), 32'd1);
        if (exp_bank_q.size() != 0)
          checkOutput("stream.we", bank_we, 3'(3'b001 << exp_bank_q[0]));
      end
      if (wr_done) begin
        checkOutput("stream.done_pending", 32'(exp_data_q.size() != 0), 32'd1);
        if (exp_data_q.size() != 0) begin
          checkOutput("stream.data", bank_data, exp_data_q[0]);
          checkOutput("stream.addr", bank_addr, 24'(exp_addr_q[0]) << (ADDR_W * exp_bank_q[0]));
          void'(exp_bank_q.pop_front());
          void'(exp_data_q.pop_front());
          void'(exp_addr_q.pop_front());
        end
        if (n_done > 0)
          checkOutput("stream.interval", cyc - last_done_cyc, 5);
        last_done_cyc = cyc;
        n_done++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DATA_W-1:0] sd [N_STREAM];
    logic [ADDR_W-1:0] sa [N_STREAM];
    logic [SEL_W-1:0]  sb [N_STREAM];
    int sent, refuse_at, run_len, k;
    logic run_open, activity;

    //            valid data        addr   bank clr  rdy e_data      e_addr      e_we    bsy dn err
    vecs[0]  = '{1'b1, 24'hA5A5A5, 8'h3C, 2'd1, 1'b0, 1'b1, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 24'hFFFFFF, 8'hFF, 2'd3, 1'b0, 1'b1, 24'h000000, 24'h000000, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 24'h123456, 8'h77, 2'd0, 1'b0, 1'b1, 24'hA5A5A5, 24'h003C00, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 24'h000000, 8'h00, 2'd0, 1'b0, 1'b1, 24'hA5A5A5, 24'h003C00, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 24'h000000, 8'h00, 2'd0, 1'b0, 1'b1, 24'hA5A5A5, 24'h003C00, 3'b010, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 24'h000000, 8'h00, 2'd0, 1'b0, 1'b1, 24'hA5A5A5, 24'h003C00, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 24'h000000, 8'h00, 2'd0, 1'b0, 1'b1, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 24'h111111, 8'h11, 2'd3, 1'b0, 1'b1, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 24'h222222, 8'h22, 2'd2, 1'b0, 1'b1, 24'h000000, 24'h000000, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 24'h000000, 8'h00, 2'd0, 1'b0, 1'b1, 24'h000000, 24'h000000, 3'b000, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 24'h000000, 8'h00, 2'd0, 1'b0, 1'b1, 24'h222222, 24'h220000, 3'b000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 24'h000000, 8'h00, 2'd0, 1'b0, 1'b1, 24'h222222, 24'h220000, 3'b100, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 24'h000000, 8'h00, 2'd0, 1'b0, 1'b1, 24'h222222, 24'h220000, 3'b100, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 24'h000000, 8'h00, 2'd0, 1'b0, 1'b1, 24'h222222, 24'h220000, 3'b000, 1'b1, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 24'h000000, 8'h00, 2'd0, 1'b1, 1'b1, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 24'h000000, 8'h00, 2'd0, 1'b0, 1'b1, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 24'h333333, 8'h33, 2'd3, 1'b0, 1'b1, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 24'h000000, 8'h00, 2'd0, 1'b1, 1'b1, 24'h000000, 24'h000000, 3'b000, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 24'h000000, 8'h00, 2'd0, 1'b0, 1'b1, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 24'h000000, 8'h00, 2'd0, 1'b1, 1'b1, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 24'h000000, 8'h00, 2'd0, 1'b0, 1'b1, 24'h000000, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_addr  = '0;
    in_bank  = '0;
    err_clr  = 1'b0;
    #2;
    checkOutput("reset.in_ready", in_ready, 1);
    checkOutput("reset.bank_data", bank_data, 0);
    checkOutput("reset.bank_addr", bank_addr, 0);
    checkOutput("reset.bank_we", bank_we, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.wr_done", wr_done, 0);
    checkOutput("reset.err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed per-cycle vectors
    for (int i = 0; i < N_VEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d.in_ready", i), in_ready, vecs[i].e_ready);
      checkOutput($sformatf("v%0d.bank_data", i), bank_data, vecs[i].e_data);
      checkOutput($sformatf("v%0d.bank_addr", i), bank_addr, vecs[i].e_addr);
      checkOutput($sformatf("v%0d.bank_we", i), bank_we, vecs[i].e_we);
      checkOutput($sformatf("v%0d.busy", i), busy, vecs[i].e_busy);
      checkOutput($sformatf("v%0d.wr_done", i), wr_done, vecs[i].e_done);
      checkOutput($sformatf("v%0d.err", i), err, vecs[i].e_err);
    end
    @(negedge clk);
    in_valid = 1'b0;
    err_clr  = 1'b0;
    @(negedge clk);

    // Saturated stream: FIFO fills, pushes are refused while full, and every
    // entry must come out once, in order, across pointer wrap.
    for (int i = 0; i < N_STREAM; i++) begin
      sd[i] = 24'($urandom);
      sa[i] = 8'(i * 17 + 5);
      sb[i] = 2'(i % 3);
    end
    sent      = 0;
    refuse_at = -1;
    run_len   = 0;
    run_open  = 1'b1;
    n_done    = 0;
    mon_en    = 1'b1;
    for (int c = 0; c < 300 && n_done < N_STREAM; c++) begin
      @(negedge clk);
      if (sent < N_STREAM) begin
        in_valid = 1'b1;
        in_data  = sd[sent];
        in_addr  = sa[sent];
        in_bank  = sb[sent];
        if (in_ready) begin
          exp_bank_q.push_back(sb[sent]);
          exp_data_q.push_back(sd[sent]);
          exp_addr_q.push_back(sa[sent]);
          sent++;
          if (refuse_at >= 0) run_open = 1'b0;
        end else begin
          if (refuse_at < 0) refuse_at = sent;
          if (run_open) run_len++;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;
    checkOutput("stream.writes_done", n_done, N_STREAM);
    checkOutput("stream.first_refusal_after", refuse_at, 5);
    checkOutput("stream.first_refusal_len", run_len, 2);
    checkOutput("stream.leftover", exp_data_q.size(), 0);
    checkOutput("stream.idle_busy", busy, 0);

    // Reset in the middle of a write, with another request still queued
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 24'hABCDEF;
    in_addr  = 8'h5A;
    in_bank  = 2'd0;
    @(negedge clk);
    in_data  = 24'h654321;
    in_addr  = 8'h66;
    in_bank  = 2'd2;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (bank_we == '0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("rst_mid.reached_write", bank_we, 3'b001);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid.bank_we", bank_we, 0);
    checkOutput("rst_mid.bank_addr", bank_addr, 0);
    checkOutput("rst_mid.bank_data", bank_data, 0);
    checkOutput("rst_mid.busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_mid.in_ready", in_ready, 1);
    activity = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      activity = activity | wr_done | (bank_we != '0) | busy;
    end
    checkOutput("rst_mid.no_activity", activity, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
